// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants and format classification shared by the encoder blocks.
package rv_isa_pkg;

    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_OP     = 5'b01100;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
    } fmt_e;

    function automatic fmt_e classify(input logic [4:0] op);
        fmt_e f;
        case (op)
            OP_LUI, OP_AUIPC:         f = FMT_U;
            OP_JAL:                   f = FMT_J;
            OP_JALR, OP_LOAD, OP_IMM: f = FMT_I;
            OP_BRANCH:                f = FMT_B;
            OP_STORE:                 f = FMT_S;
            OP_OP:                    f = FMT_R;
            default:                  f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/instr_encoder_imm_packer.sv
// Combinational immediate scatter into its RV32I bit positions; range checking of the
// immediate is compiled in only when ENC_RANGE_CHECK_EN is defined.
module imm_packer
    import rv_isa_pkg::*;
(
    input  fmt_e        i_fmt,
    input  logic [31:0] i_imm,
    output logic [31:0] o_bits,
    output logic        o_range_err
);

    always_comb begin
        o_bits = 32'h0;
        case (i_fmt)
            FMT_I: o_bits = {i_imm[11:0], 20'h0};
            FMT_S: o_bits = {i_imm[11:5], 13'h0, i_imm[4:0], 7'h0};
            FMT_B: o_bits = {i_imm[12], i_imm[10:5], 13'h0, i_imm[4:1], i_imm[11], 7'h0};
            FMT_U: o_bits = {i_imm[31:12], 12'h0};
            FMT_J: o_bits = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'h0};
            default: o_bits = 32'h0;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    // Representable iff every bit above the field's sign bit matches the sign bit.
    logic w_sext11, w_sext12, w_sext20;
    assign w_sext11 = (i_imm[31:11] == {21{i_imm[11]}});
    assign w_sext12 = (i_imm[31:12] == {20{i_imm[12]}});
    assign w_sext20 = (i_imm[31:20] == {12{i_imm[20]}});

    always_comb begin
        o_range_err = 1'b0;
        case (i_fmt)
            FMT_I, FMT_S: o_range_err = !w_sext11;
            FMT_B:        o_range_err = i_imm[0] || !w_sext12;
            FMT_J:        o_range_err = i_imm[0] || !w_sext20;
            FMT_U:        o_range_err = |i_imm[11:0];
            default:      o_range_err = 1'b0;
        endcase
    end
`else
    assign o_range_err = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Two-stage RV32I field-to-word encoder with valid/ready on both sides.
// Optional immediate range checking via ENC_RANGE_CHECK_EN (see imm_packer).
module instr_encoder
    import rv_isa_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count
);

    logic             r_vld_p1;
    fmt_e             r_fmt_p1;
    logic [4:0]       r_op_p1, r_rd_p1, r_rs1_p1, r_rs2_p1;
    logic [2:0]       r_f3_p1;
    logic [6:0]       r_f7_p1;
    logic [31:0]      r_imm_p1;
    logic             r_vld_p2;
    logic [31:0]      r_instr_p2;
    logic             r_err_p2;
    logic [CNT_W-1:0] r_count;

    logic        w_s2_ready, w_s1_adv, w_out_xfer;
    logic [31:0] w_imm_bits, w_word;
    logic        w_range_err;

    assign w_s2_ready = !r_vld_p2 || out_ready;
    assign w_s1_adv   = r_vld_p1 && w_s2_ready;
    assign in_ready   = !r_vld_p1 || w_s1_adv;
    assign w_out_xfer = r_vld_p2 && out_ready;

    // ---- S1: latch fields and classify format ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
            r_fmt_p1 <= FMT_BAD;
            r_op_p1  <= 5'h0;
            r_f3_p1  <= 3'h0;
            r_f7_p1  <= 7'h0;
            r_rd_p1  <= 5'h0;
            r_rs1_p1 <= 5'h0;
            r_rs2_p1 <= 5'h0;
            r_imm_p1 <= 32'h0;
        end else if (in_ready) begin
            r_vld_p1 <= in_valid;
            if (in_valid) begin
                r_fmt_p1 <= classify(opcode);
                r_op_p1  <= opcode;
                r_f3_p1  <= funct3;
                r_f7_p1  <= funct7;
                r_rd_p1  <= rd;
                r_rs1_p1 <= rs1;
                r_rs2_p1 <= rs2;
                r_imm_p1 <= imm;
            end
        end
    end

    imm_packer u_imm_packer (
        .i_fmt       (r_fmt_p1),
        .i_imm       (r_imm_p1),
        .o_bits      (w_imm_bits),
        .o_range_err (w_range_err)
    );

    always_comb begin
        w_word = NOP;
        case (r_fmt_p1)
            FMT_R:        w_word = {r_f7_p1, r_rs2_p1, r_rs1_p1, r_f3_p1, r_rd_p1, r_op_p1, 2'b11};
            FMT_I:        w_word = w_imm_bits | {12'h0, r_rs1_p1, r_f3_p1, r_rd_p1, r_op_p1, 2'b11};
            FMT_S, FMT_B: w_word = w_imm_bits | {7'h0, r_rs2_p1, r_rs1_p1, r_f3_p1, 5'h0, r_op_p1, 2'b11};
            FMT_U, FMT_J: w_word = w_imm_bits | {20'h0, r_rd_p1, r_op_p1, 2'b11};
            default:      w_word = NOP;
        endcase
    end

    // ---- S2: pack and hold until downstream accepts ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p2   <= 1'b0;
            r_instr_p2 <= 32'h0;
            r_err_p2   <= 1'b0;
        end else if (w_s2_ready) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_instr_p2 <= w_word;
                r_err_p2   <= (r_fmt_p1 == FMT_BAD) || w_range_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_count <= '0;
        else if (w_out_xfer) r_count <= r_count + CNT_W'(1);
    end

    assign out_valid = r_vld_p2;
    assign out_instr = r_instr_p2;
    assign out_err   = r_err_p2;
    assign enc_count = r_count;

endmodule
